// File: rtl/or2_arbiter_pkg.sv
// or2_arbiter_pkg: shared FSM state encoding and default sizes for the OR arbiter slice
package or2_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/or2_arbiter_if.sv
// or2_arbiter_if: client-side bus of the OR arbiter
// req/a_in/b_in: per-requester request and packed operands (client -> arbiter)
// gnt/result/done/busy: one-hot grant, OR result, completion pulse, busy flag (arbiter -> client)
interface or2_arbiter_if import or2_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0] result;
  logic [NUM_REQ-1:0] done;
  logic busy;
  modport master (output req, a_in, b_in, input gnt, result, done, busy);
  modport slave (input req, a_in, b_in, output gnt, result, done, busy);
endinterface

// File: rtl/or2_arbiter_unit.sv
// or2_unit: registered OR datapath; y <= a | b when en, otherwise holds
// ports: clk, rst (async active-high), en, a, b, y
module or2_unit import or2_arbiter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_ff @(posedge clk or posedge rst)
    if (rst) y <= '0;
    else if (en) y <= a | b;
endmodule

// File: rtl/or2_arbiter.sv
// or2_arbiter: round-robin arbiter sharing one registered OR unit among NUM_REQ requesters
// ports: clk, rst (async active-high), bus (or2_arbiter_if.slave: req/a_in/b_in in, gnt/result/done/busy out)
module or2_arbiter import or2_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst,
  or2_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  state_t state;
  logic [NUM_REQ-1:0] gnt_q, done_q;
  logic busy_q;
  logic [PW-1:0] sel, last_ptr, nxt;
  logic [WIDTH-1:0] a_lat, b_lat, y;
  // Scan downward so the smallest offset after last_ptr is the one that sticks.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [PW-1:0] last);
    rr_pick = last;
    for (int i = NUM_REQ; i >= 1; i--)
      if (r[(int'(last) + i) % NUM_REQ]) rr_pick = PW'((int'(last) + i) % NUM_REQ);
  endfunction
  assign nxt = rr_pick(bus.req, last_ptr);
  or2_unit #(.WIDTH(WIDTH)) u_or (
    .clk(clk),
    .rst(rst),
    .en(state == ST_EXEC),
    .a(a_lat),
    .b(b_lat),
    .y(y)
  );
  assign bus.gnt = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.result = y;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      gnt_q <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
      sel <= '0;
      last_ptr <= PW'(NUM_REQ - 1);
      a_lat <= '0;
      b_lat <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (|bus.req) begin
            sel <= nxt;
            gnt_q <= NUM_REQ'(1) << nxt;
            a_lat <= bus.a_in[int'(nxt)*WIDTH +: WIDTH];
            b_lat <= bus.b_in[int'(nxt)*WIDTH +: WIDTH];
            busy_q <= 1'b1;
            state <= ST_EXEC;
          end
        ST_EXEC: begin
          done_q <= gnt_q;
          state <= ST_DONE;
        end
        ST_DONE: begin
          gnt_q <= '0;
          done_q <= '0;
          busy_q <= 1'b0;
          last_ptr <= sel;
          state <= ST_IDLE;
        end
        default: begin
          gnt_q <= '0;
          done_q <= '0;
          busy_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_or2_arbiter.sv
// tb_or2_arbiter: directed bench with a transaction-level model checked every cycle plus literal checks
module tb_or2_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  or2_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus();
  or2_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int m_last, m_phase, m_sel;
  logic [W-1:0] m_a, m_b, m_res;
  int glog[$];
  logic [N-1:0] prev_gnt = '0;
  int done_cnt[N];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: an operation is granted when idle, completes two cycles later, three cycles in total.
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_last = N - 1;
      m_phase = 0;
      m_res = '0;
      m_sel = 0;
    end else if (m_phase == 0) begin
      if (bus.req != 0) begin
        for (int i = 1; i <= N; i++)
          if (bus.req[(m_last + i) % N]) begin
            m_sel = (m_last + i) % N;
            break;
          end
        m_a = bus.a_in[m_sel*W +: W];
        m_b = bus.b_in[m_sel*W +: W];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_res = m_a | m_b;
      m_phase = 2;
    end else begin
      m_last = m_sel;
      m_phase = 0;
    end
  always @(negedge clk) begin
    chk("gnt", 32'(bus.gnt), m_phase != 0 ? 32'(N'(1) << m_sel) : 32'd0);
    chk("done", 32'(bus.done), m_phase == 2 ? 32'(N'(1) << m_sel) : 32'd0);
    chk("busy", 32'(bus.busy), 32'(m_phase != 0));
    chk("result", 32'(bus.result), 32'(m_res));
    chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
    if (bus.gnt != 0 && prev_gnt == 0) glog.push_back($clog2(bus.gnt));
    prev_gnt = bus.gnt;
    for (int i = 0; i < N; i++) if (bus.done[i]) done_cnt[i]++;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    cyc(2);
    rst = 1'b0;
    // single request from requester 1
    bus.req = 4'b0010;
    bus.a_in[1*W +: W] = 8'hA0;
    bus.b_in[1*W +: W] = 8'h05;
    cyc(1);
    chk("t2_gnt", 32'(bus.gnt), 32'b0010);
    cyc(1);
    chk("t2_done", 32'(bus.done), 32'b0010);
    chk("t2_result", 32'(bus.result), 32'hA5);
    bus.req = '0;
    cyc(1);
    chk("t2_gnt_low", 32'(bus.gnt), 32'd0);
    chk("t2_busy_low", 32'(bus.busy), 32'd0);
    // reset during EXEC drops the operation
    bus.req = 4'b0001;
    bus.a_in[0 +: W] = 8'h11;
    bus.b_in[0 +: W] = 8'h22;
    cyc(1);
    chk("t1_gnt_pre", 32'(bus.gnt), 32'b0001);
    #2 rst = 1'b1;
    cyc(1);
    chk("t1_gnt", 32'(bus.gnt), 32'd0);
    chk("t1_done", 32'(bus.done), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_result", 32'(bus.result), 32'h00);
    bus.req = '0;
    rst = 1'b0;
    cyc(1);
    // all requesting after reset
    glog.delete();
    bus.req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      bus.a_in[i*W +: W] = 8'(8'h10 << i);
      bus.b_in[i*W +: W] = 8'(i + 1);
    end
    cyc(15);
    bus.req = '0;
    cyc(4);
    chk("t3_ngrants", 32'(glog.size()), 32'd5);
    if (glog.size() == 5) begin
      chk("t3_g0", 32'(glog[0]), 32'd0);
      chk("t3_g1", 32'(glog[1]), 32'd1);
      chk("t3_g2", 32'(glog[2]), 32'd2);
      chk("t3_g3", 32'(glog[3]), 32'd3);
      chk("t3_g4", 32'(glog[4]), 32'd0);
    end
    // operand change after grant is ignored
    bus.req = 4'b0001;
    bus.a_in[0 +: W] = 8'h0F;
    bus.b_in[0 +: W] = 8'h00;
    cyc(1);
    bus.a_in[0 +: W] = 8'hF0;
    cyc(1);
    chk("t4_done", 32'(bus.done), 32'b0001);
    chk("t4_result", 32'(bus.result), 32'h0F);
    bus.req = '0;
    cyc(1);
    // requester 2 drops req in EXEC, requester 3 is next
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    bus.req = 4'b0100;
    bus.a_in[2*W +: W] = 8'h3C;
    bus.b_in[2*W +: W] = 8'hC3;
    bus.a_in[3*W +: W] = 8'h81;
    bus.b_in[3*W +: W] = 8'h18;
    cyc(1);
    chk("t5_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b1000;
    cyc(1);
    chk("t5_done", 32'(bus.done), 32'b0100);
    chk("t5_result", 32'(bus.result), 32'hFF);
    cyc(2);
    chk("t5_next_gnt", 32'(bus.gnt), 32'b1000);
    cyc(1);
    chk("t5_result3", 32'(bus.result), 32'h99);
    bus.req = '0;
    cyc(1);
    chk("t5_done2_once", 32'(done_cnt[2]), 32'd1);
    // rotation between 0 and 3 starting after last grant 3
    glog.delete();
    bus.req = 4'b1001;
    cyc(9);
    bus.req = '0;
    cyc(4);
    chk("t6_ngrants", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      chk("t6_g0", 32'(glog[0]), 32'd0);
      chk("t6_g1", 32'(glog[1]), 32'd3);
      chk("t6_g2", 32'(glog[2]), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
